// File: rtl/u8out_wrsched_if.sv
// Capture bus from the MAC lanes and byte write port toward output memory.
// The scheduler connects as slave.
interface u8out_wrsched_if #(
  parameter int Np = 32,
  parameter int AW = 29
) ();
  logic                   acvalid;
  logic [Np-1:0]          oen;
  logic [Np-1:0][AW-1:0]  out_adr;
  logic [Np-1:0][7:0]     accd;
  logic                   out_rdy;
  logic                   mw_valid;
  logic [AW-1:0]          mw_adr;
  logic [7:0]             mw_data;
  logic                   mw_ready;

  modport master (
    output acvalid, oen, out_adr, accd, mw_ready,
    input  out_rdy, mw_valid, mw_adr, mw_data
  );

  modport slave (
    input  acvalid, oen, out_adr, accd, mw_ready,
    output out_rdy, mw_valid, mw_adr, mw_data
  );
endinterface

// File: rtl/u8out_wrsched.sv
// Double-banked output write scheduler: captures Np lane results per acvalid
// and drains them as serial byte writes in capture order.
module u8out_wrsched #(
  parameter int Np = 32,
  parameter int AW = 29,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  u8out_wrsched_if.slave      bus,
  output logic                busy,
  output logic [CW-1:0]       wcount,
  output logic                ovf
);
  localparam int LW = (Np > 1) ? $clog2(Np) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t                 state;
  logic [1:0]             bank_full;
  logic [Np-1:0]          bank_oen [2];
  logic [Np-1:0][AW-1:0]  bank_adr [2];
  logic [Np-1:0][7:0]     bank_dat [2];
  logic                   rd_ptr;
  logic [LW-1:0]          cur;

  logic                   cap_req;
  logic                   cap_ok;
  logic                   cap_bank;
  logic                   handshake;
  logic                   drain_done;
  logic [Np-1:0]          pend_load;
  logic [Np-1:0]          pend_next;
  logic [LW-1:0]          lane_load;
  logic [LW-1:0]          lane_next;
  logic                   any_next;
  logic [1:0]             full_nxt;

  assign cap_req    = bus.acvalid && (|bus.oen);
  // Full status is taken before the edge, so a bank freed this edge is not reusable yet.
  assign cap_ok     = cap_req && !(&bank_full);
  assign cap_bank   = bank_full[0];
  assign handshake  = (state == WRITE) && bus.mw_ready;
  assign drain_done = handshake && !any_next;
  assign busy       = (|bank_full) || (state != IDLE);

  always_comb begin
    pend_load = bank_oen[rd_ptr];
    pend_next = pend_load;
    pend_next[cur] = 1'b0;
    lane_load = '0;
    lane_next = '0;
    for (int unsigned i = 0; i < Np; i++) begin
      if (pend_load[Np-1-i]) lane_load = LW'(Np-1-i);
      if (pend_next[Np-1-i]) lane_next = LW'(Np-1-i);
    end
    any_next = |pend_next;
  end

  always_comb begin
    full_nxt = bank_full;
    if (drain_done) full_nxt[rd_ptr] = 1'b0;
    if (cap_ok)     full_nxt[cap_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cap_ok) begin
      bank_adr[cap_bank] <= bus.out_adr;
      bank_dat[cap_bank] <= bus.accd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bank_full    <= '0;
      bank_oen[0]  <= '0;
      bank_oen[1]  <= '0;
      rd_ptr       <= 1'b0;
      cur          <= '0;
      bus.out_rdy  <= 1'b0;
      bus.mw_valid <= 1'b0;
      bus.mw_adr   <= '0;
      bus.mw_data  <= '0;
      wcount       <= '0;
      ovf          <= 1'b0;
    end else begin
      bank_full   <= full_nxt;
      bus.out_rdy <= !(&full_nxt);
      if (cap_req && (&bank_full)) ovf <= 1'b1;

      if (drain_done)
        rd_ptr <= ~rd_ptr;
      else if (cap_ok && (bank_full == 2'b00))
        rd_ptr <= 1'b0;

      case (state)
        IDLE: begin
          if (bank_full[rd_ptr]) state <= LOAD;
        end
        LOAD: begin
          cur          <= lane_load;
          bus.mw_adr   <= bank_adr[rd_ptr][lane_load];
          bus.mw_data  <= bank_dat[rd_ptr][lane_load];
          bus.mw_valid <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          if (bus.mw_ready) begin
            wcount                <= wcount + CW'(1);
            bank_oen[rd_ptr][cur] <= 1'b0;
            if (any_next) begin
              cur         <= lane_next;
              bus.mw_adr  <= bank_adr[rd_ptr][lane_next];
              bus.mw_data <= bank_dat[rd_ptr][lane_next];
            end else begin
              bus.mw_valid <= 1'b0;
              state        <= bank_full[~rd_ptr] ? LOAD : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cap_ok) bank_oen[cap_bank] <= bus.oen;
    end
  end
endmodule

// File: tb/tb_u8out_wrsched.sv
// Scoreboard bench for u8out_wrsched: expected writes are queued at capture
// time and compared as the write port presents them.
module tb_u8out_wrsched;
  localparam int NP = 32;
  localparam int AW = 29;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [CW-1:0]  wcount;
  logic           ovf;

  u8out_wrsched_if #(.Np(NP), .AW(AW)) bus ();

  u8out_wrsched #(.Np(NP), .AW(AW), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .wcount (wcount),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+7:0] sb [$];
  int rdy_mode = 0;
  int unsigned cyc = 0;

  logic [NP-1:0][AW-1:0] ga;
  logic [NP-1:0][7:0]    gd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mk(input int unsigned abase, input int unsigned dbase, input int unsigned dstep);
    for (int unsigned i = 0; i < NP; i++) begin
      ga[i] = AW'(abase + i);
      gd[i] = 8'(dbase + i * dstep);
    end
  endtask

  task automatic drive(input logic [NP-1:0] en, input bit exp_cap);
    bus.acvalid = 1'b1;
    bus.oen     = en;
    bus.out_adr = ga;
    bus.accd    = gd;
    if (exp_cap)
      for (int unsigned i = 0; i < NP; i++)
        if (en[i]) sb.push_back({ga[i], gd[i]});
  endtask

  task automatic pulse(input logic [NP-1:0] en, input bit exp_cap);
    @(posedge clk); #1;
    drive(en, exp_cap);
    @(posedge clk); #1;
    bus.acvalid = 1'b0;
    bus.oen     = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  // mw_ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = held low
  initial begin
    bus.mw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.mw_ready = 1'b1;
        1:       bus.mw_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.mw_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.mw_valid) begin
        if (sb.size() == 0) begin
          check("spurious_write", 64'd1, 64'd0);
        end else begin
          check("mw_adr", 64'(bus.mw_adr), 64'(sb[0][AW+7:8]));
          check("mw_data", 64'(bus.mw_data), 64'(sb[0][7:0]));
          if (bus.mw_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] base;
    logic [NP-1:0] en;
    int unsigned   nen;
    bit            seen;

    rst = 1'b1;
    bus.acvalid = 1'b0;
    bus.oen     = '0;
    bus.out_adr = '0;
    bus.accd    = '0;
    #1;
    check("rst_mw_valid", 64'(bus.mw_valid), 64'd0);
    check("rst_mw_adr",   64'(bus.mw_adr),   64'd0);
    check("rst_mw_data",  64'(bus.mw_data),  64'd0);
    check("rst_busy",     64'(busy),         64'd0);
    check("rst_wcount",   64'(wcount),       64'd0);
    check("rst_ovf",      64'(ovf),          64'd0);
    #21 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(bus.out_rdy), 64'd1);

    // 1: full group, latency two edges
    mk(32'h100, 0, 3);
    pulse('1, 1'b1);
    @(negedge clk);
    check("t1_valid_t0", 64'(bus.mw_valid), 64'd0);
    check("t1_busy",     64'(busy),         64'd1);
    @(negedge clk);
    check("t1_valid_t1", 64'(bus.mw_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_t2", 64'(bus.mw_valid), 64'd1);
    wait_idle(100);
    check("t1_wcount", 64'(wcount), 64'd32);
    check("t1_busy_end", 64'(busy), 64'd0);

    // 2: sparse lanes 0, 5, 31 back to back, then an all-disabled strobe
    base = wcount;
    mk(32'h200, 8'hA0, 1);
    en = '0; en[0] = 1'b1; en[5] = 1'b1; en[31] = 1'b1;
    pulse(en, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mw_valid;
    end
    check("t2_valid_seen", 64'(seen), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("t2_wcount_2", 64'(wcount), 64'(base + CW'(2)));
    check("t2_valid_2",  64'(bus.mw_valid), 64'd1);
    @(negedge clk);
    check("t2_wcount_3", 64'(wcount), 64'(base + CW'(3)));
    check("t2_valid_3",  64'(bus.mw_valid), 64'd0);
    wait_idle(20);
    base = wcount;
    pulse('0, 1'b0);
    @(negedge clk);
    check("t2_noen_rdy",  64'(bus.out_rdy), 64'd1);
    check("t2_noen_ovf",  64'(ovf),         64'd0);
    check("t2_noen_busy", 64'(busy),        64'd0);
    repeat (4) @(negedge clk);
    check("t2_noen_wcount", 64'(wcount), 64'(base));
    check("t2_noen_valid",  64'(bus.mw_valid), 64'd0);

    // 3: toggling ready, random enables
    rdy_mode = 1;
    base = wcount;
    nen = 0;
    for (int g = 0; g < 2; g++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        ga[i] = AW'($urandom);
        gd[i] = 8'($urandom);
      end
      en = NP'($urandom);
      if (en == '0) en[3] = 1'b1;
      nen += $countones(en);
      pulse(en, 1'b1);
    end
    wait_idle(400);
    check("t3_wcount", 64'(wcount), 64'(base + CW'(nen)));
    rdy_mode = 0;

    // 4: three strobes with ready held low, third dropped
    rdy_mode = 2;
    @(posedge clk);
    base = wcount;
    for (int g = 0; g < 3; g++) begin
      mk(32'h300 + 32'(g) * 32'h100, 32'(g) * 64, 1);
      @(posedge clk); #1;
      drive('1, g < 2);
    end
    @(posedge clk); #1;
    bus.acvalid = 1'b0;
    bus.oen     = '0;
    @(negedge clk);
    check("t4_rdy_full", 64'(bus.out_rdy),  64'd0);
    check("t4_ovf",      64'(ovf),          64'd1);
    check("t4_valid",    64'(bus.mw_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("t4_stalled_wcount", 64'(wcount), 64'(base));
    rdy_mode = 0;
    wait_idle(200);
    check("t4_wcount",  64'(wcount),      64'(base + CW'(64)));
    check("t4_rdy_end", 64'(bus.out_rdy), 64'd1);
    check("t4_ovf_sticky", 64'(ovf),      64'd1);

    // 5: reset mid-drain
    base = wcount;
    mk(32'h500, 8'h80, 1);
    pulse('1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (wcount == base + CW'(10));
    end
    check("t5_reached_10", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", 64'(bus.mw_valid), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy",   64'(busy),        64'd0);
    check("t5_wcount", 64'(wcount),      64'd0);
    check("t5_rdy",    64'(bus.out_rdy), 64'd1);
    check("t5_ovf",    64'(ovf),         64'd0);
    mk(32'h600, 8'h11, 5);
    pulse('1, 1'b1);
    wait_idle(100);
    check("t5_new_wcount", 64'(wcount), 64'd32);

    // 6: a group every 32 cycles
    base = wcount;
    for (int k = 0; k < 4; k++) begin
      mk(32'h1000 + 32'(k) * 32, 32'(k) * 7, 1);
      @(posedge clk); #1;
      check("t6_rdy_at_strobe", 64'(bus.out_rdy), 64'd1);
      drive('1, 1'b1);
      @(posedge clk); #1;
      bus.acvalid = 1'b0;
      bus.oen     = '0;
      repeat (30) @(posedge clk);
    end
    wait_idle(200);
    check("t6_wcount", 64'(wcount), 64'(base + CW'(128)));
    check("t6_ovf",    64'(ovf),    64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/u8out_wrsched.md
Name: u8out_wrsched

Overview:
- Output write scheduler between the Np parallel u8mac lanes and the single byte-wide output memory write port.
- On each acvalid pulse it captures every lane's quantized result and address into one of two banks, then drains them as serial byte writes over a valid/ready port.
- It back-pressures the address generator through out_rdy, so the MAC array never outruns the memory port.

Parameters:
- Np, 32, number of parallel MAC lanes.
- AW, 29, byte address width.
- CW, 16, width of the completed-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- acvalid  in  1  MAC result valid strobe, single-cycle per output group.
- oen  in  Np x 1  per-lane output enable, sampled with acvalid.
- out_adr  in  Np x AW  per-lane output byte address, sampled with acvalid.
- accd  in  Np x 8  per-lane u8 result, sampled with acvalid.
- out_rdy  out  1  to address generator: at least one bank free.
- mw_valid  out  1  write request.
- mw_adr  out  AW  write byte address.
- mw_data  out  8  write byte.
- mw_ready  in  1  memory accepts the write when mw_valid and mw_ready are both 1 at a clk edge.
- busy  out  1  any bank holds undrained data.
- wcount  out  CW  completed writes since reset; wraps modulo 2^CW.
- ovf  out  1  sticky flag: a capture was dropped because no bank was free.

Behaviour:
- Reset (async, rst=1):
  - Both banks empty, FSM in IDLE.
  - mw_valid=0, mw_adr=0, mw_data=0, busy=0, wcount=0, ovf=0.
  - out_rdy=1 from the first edge after rst is released.
  - Reset mid-drain discards all buffered data with no partial write. mw_valid drops asynchronously.
- Capture:
  - On a clk edge with acvalid=1 and any oen=1, all Np {oen, out_adr, accd} are written into the free bank. If both banks are free, bank 0 is used.
  - Banks fill alternately. Drain order equals capture order.
  - If acvalid=1 with all oen=0, nothing is captured, no bank is consumed and ovf is unchanged.
  - If acvalid=1, any oen=1 and both banks are full, the data is dropped and ovf is set to 1. ovf holds until reset.
  - A capture into a bank freed on the same edge is not allowed. out_rdy is registered and reflects state after each edge.
- out_rdy = (number of full banks) < 2, registered.
- Drain FSM, states:
  - IDLE:
    - Holds mw_valid=0.
    - Moves to LOAD when the oldest bank is full. A bank captured at edge t is seen at t+1.
  - LOAD:
    - Priority-encodes the lowest enabled lane not yet written in the drain bank.
    - Drives mw_adr and mw_data from that lane and sets mw_valid=1 on the next edge.
    - Goes to WRITE.
  - WRITE:
    - mw_valid, mw_adr and mw_data stay stable until handshake.
    - On handshake, wcount increments and the lane is marked done.
    - If another enabled lane remains, the next lane's address and data load on the same edge and the FSM stays in WRITE. This gives 1 write per cycle while mw_ready=1.
    - Otherwise the bank is freed. If the other bank is full, go to LOAD, else go to IDLE, with mw_valid=0.
- Latency: acvalid at edge t gives mw_valid=1 at edge t+2 (IDLE to LOAD, LOAD to WRITE) when both banks were empty.
- Write order:
  - Within a bank, ascending lane index, skipping oen=0 lanes.
  - Disabled lanes never cost a cycle.
- Simultaneous events:
  - Capture into the free bank and drain of the other bank proceed in parallel.
  - A drain completing on the same edge as acvalid while both banks were full still counts as full, so the data is dropped and ovf is set.
- busy = any bank full, or FSM not IDLE.
- wcount wraps from 2^CW-1 to 0 silently.
- mw_ready is ignored while mw_valid=0.

Test Plan:
1. Single group, Np=32, all oen=1, out_adr[i]=0x100+i, accd[i]=i*3, mw_ready=1 → mw_valid rises 2 cycles after acvalid; 32 consecutive writes, 0x100..0x11F, data 0..93 step 3; wcount=32; busy=0 one cycle after the last write.
2. oen only on lanes 0, 5 and 31 → exactly 3 writes in order 0, 5, 31 on consecutive cycles; all-oen=0 acvalid → no writes, out_rdy stays 1, ovf=0.
3. mw_ready toggling 1,0,0,1 repeating → mw_adr and mw_data held stable while mw_ready=0; every lane written exactly once; wcount equals the number of enabled lanes.
4. Three acvalid pulses back-to-back with mw_ready=0 → first two captured, out_rdy=0 after the second, third dropped with ovf=1; releasing mw_ready drains the two groups in capture order.
5. rst pulsed high mid-drain after 10 of 32 writes → mw_valid=0 immediately; after release busy=0, wcount=0, out_rdy=1, ovf=0; a new group drains normally.
6. Continuous acvalid every 32 cycles, all oen=1, mw_ready=1, 4 groups → ovf stays 0, out_rdy never 0 for more than 1 cycle, wcount=128.
